// File: rtl/tick_scheduler.sv
// Central timebase: divides the system clock into seconds, adjust-step, scan and blink enables.
// Optional blink generator is built only when TICK_SCHEDULER_BLINK_EN is defined.
module tick_scheduler #(
  parameter int unsigned SEC_DIV   = 100000000,
  parameter int unsigned HOLD_DIV  = 50000000,
  parameter int unsigned REP_DIV   = 12500000,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic adj,
  output logic sec_tick,
  output logic step_tick,
  output logic scan_tick,
  output logic blink,
  output logic adjusting
);

  localparam int unsigned SW = $clog2(SEC_DIV);
  localparam int unsigned HW = $clog2(HOLD_DIV);
  localparam int unsigned RW = $clog2(REP_DIV);
  localparam int unsigned CW = $clog2(SCAN_DIV);

  localparam logic [SW-1:0] SecLast  = SW'(SEC_DIV - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_DIV - 1);
  localparam logic [RW-1:0] RepLast  = RW'(REP_DIV - 1);
  localparam logic [CW-1:0] ScanLast = CW'(SCAN_DIV - 1);

  // Bit 1 of the encoding marks the adjust states and drives adjusting directly.
  localparam logic [1:0] StStop      = 2'b00;
  localparam logic [1:0] StRun       = 2'b01;
  localparam logic [1:0] StAdjFirst  = 2'b10;
  localparam logic [1:0] StAdjRepeat = 2'b11;

  logic [1:0]    state_q, state_d;
  logic          live_q;
  logic          adj_q;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic          sec_tick_q, sec_tick_d;
  logic          step_tick_q, step_tick_d;
  logic          scan_tick_q, scan_tick_d;
  logic          rise;
  logic [1:0]    exit_state;

  assign rise       = adj & ~adj_q;
  assign exit_state = run ? StRun : StStop;

  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    sec_tick_d  = 1'b0;
    step_tick_d = 1'b0;
    case (state_q)
      StStop: begin
        sec_cnt_d = '0;
        if (rise) begin
          state_d     = StAdjFirst;
          step_tick_d = 1'b1;
          hold_cnt_d  = '0;
        end else if (run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (rise) begin
          state_d     = StAdjFirst;
          step_tick_d = 1'b1;
          hold_cnt_d  = '0;
          sec_cnt_d   = '0;
        end else if (!run) begin
          state_d   = StStop;
          sec_cnt_d = '0;
        end else if (sec_cnt_q == SecLast) begin
          sec_cnt_d  = '0;
          sec_tick_d = 1'b1;
        end else begin
          sec_cnt_d = sec_cnt_q + 1'b1;
        end
      end
      StAdjFirst: begin
        sec_cnt_d = '0;
        // Release takes priority over an expiring hold count.
        if (!adj) begin
          state_d = exit_state;
        end else if (hold_cnt_q == HoldLast) begin
          state_d     = StAdjRepeat;
          step_tick_d = 1'b1;
          rep_cnt_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StAdjRepeat: begin
        sec_cnt_d = '0;
        if (!adj) begin
          state_d = exit_state;
        end else if (rep_cnt_q == RepLast) begin
          step_tick_d = 1'b1;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StStop;
        sec_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    scan_tick_d = (scan_cnt_q == ScanLast);
    scan_cnt_d  = scan_tick_d ? '0 : scan_cnt_q + 1'b1;
  end

  // The first edge after reset only loads adj_q, so a button held through reset is not a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q      <= 1'b0;
      adj_q       <= 1'b0;
      state_q     <= StStop;
      sec_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      sec_tick_q  <= 1'b0;
      step_tick_q <= 1'b0;
      scan_tick_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      adj_q  <= adj;
      if (live_q) begin
        state_q     <= state_d;
        sec_cnt_q   <= sec_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        scan_cnt_q  <= scan_cnt_d;
        sec_tick_q  <= sec_tick_d;
        step_tick_q <= step_tick_d;
        scan_tick_q <= scan_tick_d;
      end
    end
  end

  assign sec_tick  = sec_tick_q;
  assign step_tick = step_tick_q;
  assign scan_tick = scan_tick_q;
  assign adjusting = state_q[1];

`ifdef TICK_SCHEDULER_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (live_q) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink = blink_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV != 0);
  assign blink            = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: stimulus queues expected pulse cycles, a monitor checks
// every output on each falling edge.
module tb_tick_scheduler;

  localparam int unsigned SEC_DIV   = 10;
  localparam int unsigned HOLD_DIV  = 6;
  localparam int unsigned REP_DIV   = 3;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 5;

  logic clk = 1'b0;
  logic reset, run, adj;
  logic sec_tick, step_tick, scan_tick, blink, adjusting;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scan_base = 0;
  bit scan_on = 1'b0;
  int sec_q[$];
  int step_q[$];

  tick_scheduler #(
    .SEC_DIV  (SEC_DIV),
    .HOLD_DIV (HOLD_DIV),
    .REP_DIV  (REP_DIV),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .adj      (adj),
    .sec_tick (sec_tick),
    .step_tick(step_tick),
    .scan_tick(scan_tick),
    .blink    (blink),
    .adjusting(adjusting)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Returns 2 time units after the n-th rising edge from now.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    logic e_sec, e_step, e_scan, e_blink;
    int   dummy;
    e_sec  = (sec_q.size() > 0) && (sec_q[0] == cyc);
    e_step = (step_q.size() > 0) && (step_q[0] == cyc);
    if (e_sec) dummy = sec_q.pop_front();
    if (e_step) dummy = step_q.pop_front();
    e_scan = scan_on && (cyc > scan_base) && (((cyc - scan_base) % SCAN_DIV) == 0);
`ifdef TICK_SCHEDULER_BLINK_EN
    e_blink = scan_on && (cyc >= scan_base) && ((((cyc - scan_base) / BLINK_DIV) % 2) == 1);
`else
    e_blink = 1'b0;
`endif
    check("sec_tick", sec_tick, e_sec);
    check("step_tick", step_tick, e_step);
    check("scan_tick", scan_tick, e_scan);
    check("blink", blink, e_blink);
    check("sec_during_adjust", sec_tick & adjusting, 1'b0);
    check("sec_with_step", sec_tick & step_tick, 1'b0);
  end

  initial begin
    int r, c, d, e, f, h;
    reset = 1'b1;
    run   = 1'b0;
    adj   = 1'b0;
    tick(3);
    check("reset_adjusting", adjusting, 1'b0);

    // Run from reset: RUN entered on the second edge after release.
    run       = 1'b1;
    r         = cyc;
    scan_base = r + 1;
    scan_on   = 1'b1;
    reset     = 1'b0;
    sec_q.push_back(r + 12);
    sec_q.push_back(r + 22);
    sec_q.push_back(r + 32);
    tick(35);
    check("run_adjusting", adjusting, 1'b0);

    // Two-cycle adj pulse in RUN.
    c   = cyc;
    adj = 1'b1;
    step_q.push_back(c + 1);
    sec_q.push_back(c + 13);
    tick(1);
    check("pulse_adjusting_1", adjusting, 1'b1);
    tick(1);
    check("pulse_adjusting_2", adjusting, 1'b1);
    adj = 1'b0;
    tick(1);
    check("pulse_back_to_run", adjusting, 1'b0);
    tick(11);

    // Fifteen-cycle hold: first step, hold delay, then repeats.
    d   = cyc;
    adj = 1'b1;
    step_q.push_back(d + 1);
    step_q.push_back(d + 7);
    step_q.push_back(d + 10);
    step_q.push_back(d + 13);
    sec_q.push_back(d + 26);
    tick(8);
    check("hold_adjusting", adjusting, 1'b1);
    tick(7);
    adj = 1'b0;
    tick(1);
    check("hold_released", adjusting, 1'b0);
    tick(11);

    // Release on the cycle the hold count expires, with run dropped.
    e   = cyc;
    adj = 1'b1;
    run = 1'b0;
    step_q.push_back(e + 1);
    tick(1);
    check("expire_adjusting", adjusting, 1'b1);
    tick(5);
    adj = 1'b0;
    tick(1);
    check("expire_to_stop", adjusting, 1'b0);
    tick(5);

    // Reset in the middle of ADJ_REPEAT with adj still held.
    f   = cyc;
    adj = 1'b1;
    step_q.push_back(f + 1);
    step_q.push_back(f + 7);
    step_q.push_back(f + 10);
    tick(11);
    check("repeat_adjusting", adjusting, 1'b1);
    scan_on = 1'b0;
    reset   = 1'b1;
    #1;
    check("reset_clears_adjusting", adjusting, 1'b0);
    check("reset_clears_scan", scan_tick, 1'b0);
    check("reset_clears_step", step_tick, 1'b0);
    tick(2);
    r         = cyc;
    scan_base = r + 1;
    scan_on   = 1'b1;
    reset     = 1'b0;
    tick(5);
    check("held_through_reset", adjusting, 1'b0);
    adj = 1'b0;
    tick(2);
    h   = cyc;
    adj = 1'b1;
    step_q.push_back(h + 1);
    tick(1);
    check("re_rise_adjusting", adjusting, 1'b1);
    tick(2);
    adj = 1'b0;
    tick(2);
    check("final_stop", adjusting, 1'b0);
    tick(20);

    check("sec_queue_drained", sec_q.size() == 0, 1'b1);
    check("step_queue_drained", step_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
